// File: rtl/cpu_ctrl_seq_pkg.sv
// Shared encodings for the multi-cycle ALU control sequencer:
// opcodes, funct fields, the 4-bit ALU operation code and the FSM states.
package cpu_ctrl_seq_pkg;

  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ALU operation code is {funct7[5], funct3}; only SUB and SRA set the top bit.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_WB
  } state_e;

endpackage

// File: rtl/cpu_ctrl_seq_decode.sv
// Combinational decoder for I-type and R-type integer ALU instructions.
// Produces the ALU code, operand selection, immediate, register fields and a legality flag.
module cpu_ctrl_decode
  import cpu_ctrl_seq_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [31:0]       instr,
  output logic [3:0]        alu_op,
  output logic              is_imm,
  output logic [XLEN-1:0]   imm,
  output logic [REG_AW-1:0] rd,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  output logic              illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd     = instr[7 +: REG_AW];
  assign rs1    = instr[15 +: REG_AW];
  assign imm    = {{(XLEN-12){instr[31]}}, instr[31:20]};

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    alu_op  = ALU_ADD;
    is_imm  = 1'b0;
    rs2     = '0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        rs2    = instr[20 +: REG_AW];
        alu_op = {funct7[5], funct3};
        if (funct7 != F7_BASE && funct7 != F7_ALT)
          illegal = 1'b1;
        else if (funct7 == F7_ALT && funct3 != F3_ADD && funct3 != F3_SR)
          illegal = 1'b1;
      end
      OP_ITYPE: begin
        is_imm = 1'b1;
        // Only shifts use imm[10] as the arithmetic select; ADDI can never become SUB.
        alu_op = (funct3 == F3_SR) ? {instr[30], funct3} : {1'b0, funct3};
        if (funct3 == F3_SLL && funct7 != F7_BASE)
          illegal = 1'b1;
        if (funct3 == F3_SR && funct7 != F7_BASE && funct7 != F7_ALT)
          illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Four-state control sequencer: accept, decode, execute, write back.
// Drives the regfile read/write ports and the ALU, and counts retired and rejected instructions.
module cpu_ctrl_seq
  import cpu_ctrl_seq_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic [31:0]       cpu_instruction,
  input  logic              cpu_instruction_RDY_BSY,
  output logic              cpu_instr_ready,
  output logic [REG_AW-1:0] rf_raddr1,
  output logic [REG_AW-1:0] rf_raddr2,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  output logic [3:0]        alu_op,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  input  logic [XLEN-1:0]   alu_result,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              illegal_pulse,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [CNT_W-1:0]  illegal_cnt
);

  state_e            state;
  logic [31:0]       instr_q;
  logic [REG_AW-1:0] rd_q;
  logic [XLEN-1:0]   imm_q;
  logic [XLEN-1:0]   wdata_q;
  logic [3:0]        alu_op_q;
  logic              is_imm_q;

  logic [3:0]        dec_alu_op;
  logic              dec_is_imm;
  logic [XLEN-1:0]   dec_imm;
  logic [REG_AW-1:0] dec_rd;
  logic [REG_AW-1:0] dec_rs1;
  logic [REG_AW-1:0] dec_rs2;
  logic              dec_illegal;

  cpu_ctrl_decode #(.XLEN(XLEN), .REG_AW(REG_AW)) u_decode (
    .instr   (instr_q),
    .alu_op  (dec_alu_op),
    .is_imm  (dec_is_imm),
    .imm     (dec_imm),
    .rd      (dec_rd),
    .rs1     (dec_rs1),
    .rs2     (dec_rs2),
    .illegal (dec_illegal)
  );

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state       <= ST_IDLE;
      instr_q     <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      wdata_q     <= '0;
      alu_op_q    <= '0;
      is_imm_q    <= 1'b0;
      retired_cnt <= '0;
      illegal_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        ST_IDLE: begin
          if (cpu_instruction_RDY_BSY) begin
            instr_q <= cpu_instruction;
            state   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          rd_q     <= dec_rd;
          imm_q    <= dec_imm;
          alu_op_q <= dec_alu_op;
          is_imm_q <= dec_is_imm;
          if (dec_illegal) begin
            illegal_cnt <= illegal_cnt + CNT_W'(1);
            state       <= ST_IDLE;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          wdata_q <= alu_result;
          state   <= ST_WB;
        end
        ST_WB: begin
          retired_cnt <= retired_cnt + CNT_W'(1);
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of the state register, so reset clears them without a clock.
  always_comb begin
    cpu_instr_ready = (state == ST_IDLE);
    rf_raddr1       = '0;
    rf_raddr2       = '0;
    alu_op          = '0;
    alu_a           = '0;
    alu_b           = '0;
    rf_we           = 1'b0;
    rf_waddr        = '0;
    rf_wdata        = '0;
    illegal_pulse   = 1'b0;
    case (state)
      ST_DECODE: begin
        rf_raddr1     = dec_rs1;
        rf_raddr2     = dec_rs2;
        illegal_pulse = dec_illegal;
      end
      ST_EXEC: begin
        rf_raddr1 = dec_rs1;
        rf_raddr2 = dec_rs2;
        alu_op    = alu_op_q;
        alu_a     = rf_rdata1;
        alu_b     = is_imm_q ? imm_q : rf_rdata2;
      end
      ST_WB: begin
        rf_we    = (rd_q != '0);
        rf_waddr = rd_q;
        rf_wdata = wdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Self-checking bench for cpu_ctrl_seq with a regfile/ALU model and a writeback scoreboard.
module tb_cpu_ctrl_seq;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic [31:0] cpu_instruction;
  logic        cpu_instruction_RDY_BSY;
  logic        cpu_instr_ready;
  logic [4:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic [31:0] rf_rdata1, rf_rdata2, alu_a, alu_b, alu_result, rf_wdata;
  logic [3:0]  alu_op;
  logic        rf_we, illegal_pulse;
  logic [31:0] retired_cnt, illegal_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] wd;
  } wb_t;
  wb_t sb[$];

  logic [31:0] rf [32];

  cpu_ctrl_seq dut (
    .cpu_clk                 (cpu_clk),
    .cpu_rst                 (cpu_rst),
    .cpu_instruction         (cpu_instruction),
    .cpu_instruction_RDY_BSY (cpu_instruction_RDY_BSY),
    .cpu_instr_ready         (cpu_instr_ready),
    .rf_raddr1               (rf_raddr1),
    .rf_raddr2               (rf_raddr2),
    .rf_rdata1               (rf_rdata1),
    .rf_rdata2               (rf_rdata2),
    .alu_op                  (alu_op),
    .alu_a                   (alu_a),
    .alu_b                   (alu_b),
    .alu_result              (alu_result),
    .rf_we                   (rf_we),
    .rf_waddr                (rf_waddr),
    .rf_wdata                (rf_wdata),
    .illegal_pulse           (illegal_pulse),
    .retired_cnt             (retired_cnt),
    .illegal_cnt             (illegal_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  always @(posedge cpu_clk)
    if (rf_we && rf_waddr != 5'd0) rf[rf_waddr] <= rf_wdata;

  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_a + alu_b;
      4'b1000: alu_result = alu_a - alu_b;
      4'b0001: alu_result = alu_a << alu_b[4:0];
      4'b0010: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'b0011: alu_result = {31'd0, alu_a < alu_b};
      4'b0100: alu_result = alu_a ^ alu_b;
      4'b0101: alu_result = alu_a >> alu_b[4:0];
      4'b1101: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      4'b0110: alu_result = alu_a | alu_b;
      4'b0111: alu_result = alu_a & alu_b;
      default: alu_result = 32'd0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Writeback monitor: every rf_we pulse must match the oldest expected write.
  always @(negedge cpu_clk) begin
    wb_t e;
    if (!cpu_rst && rf_we) begin
      if (sb.size() == 0) begin
        check("spurious_rf_we", {27'd0, rf_waddr}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("wb_addr", 32'(rf_waddr), 32'(e.rd));
        check("wb_data", rf_wdata, e.wd);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!cpu_instr_ready && n < 8) begin
      @(negedge cpu_clk);
      n++;
    end
    check("ready_wait", 32'(cpu_instr_ready), 32'd1);
  endtask

  // Drives one instruction at a negedge in IDLE and follows it to completion.
  task automatic send(input logic [31:0] instr, input bit ill, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic [31:0] wd, input bit hold);
    wait_ready();
    cpu_instruction         = instr;
    cpu_instruction_RDY_BSY = 1'b1;
    if (!ill && rd != 5'd0) sb.push_back('{rd: rd, wd: wd});
    @(negedge cpu_clk);
    check("ready_low_decode", 32'(cpu_instr_ready), 32'd0);
    check("illegal_pulse", 32'(illegal_pulse), 32'(ill));
    check("alu_b_in_decode", alu_b, 32'd0);
    if (hold) cpu_instruction = $urandom;
    else cpu_instruction_RDY_BSY = 1'b0;
    if (ill) begin
      @(negedge cpu_clk);
      check("ready_after_illegal", 32'(cpu_instr_ready), 32'd1);
    end else begin
      @(negedge cpu_clk);
      check("exec_alu_op", 32'(alu_op), 32'(op));
      check("exec_alu_a", alu_a, a);
      check("exec_alu_b", alu_b, b);
      if (hold) cpu_instruction = $urandom;
      @(negedge cpu_clk);
      check("ready_low_wb", 32'(cpu_instr_ready), 32'd0);
      cpu_instruction_RDY_BSY = 1'b0;
      @(negedge cpu_clk);
      check("ready_after_wb", 32'(cpu_instr_ready), 32'd1);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rf[2] = 32'd10;
    cpu_rst                 = 1'b1;
    cpu_instruction         = 32'd0;
    cpu_instruction_RDY_BSY = 1'b0;
    repeat (2) @(negedge cpu_clk);
    check("rst_ready", 32'(cpu_instr_ready), 32'd1);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_retired", retired_cnt, 32'd0);
    check("rst_illegal", illegal_cnt, 32'd0);
    cpu_rst = 1'b0;
    @(negedge cpu_clk);

    send(32'h00500093, 0, 4'b0000, 32'd0, 32'd5,   5'd1, 32'd5, 0);          // addi x1,x0,5
    check("retired_after_addi", retired_cnt, 32'd1);
    send(32'h002001B3, 0, 4'b0000, 32'd0, 32'd10,  5'd3, 32'd10, 0);         // add x3,x0,x2
    send(32'h402081B3, 0, 4'b1000, 32'd5, 32'd10,  5'd3, 32'hFFFFFFFB, 0);   // sub x3,x1,x2
    send(32'h4030D093, 0, 4'b1101, 32'd5, 32'h403, 5'd1, 32'd0, 0);          // srai x1,x1,3
    send(32'h00000000, 1, 4'b0000, 32'd0, 32'd0,   5'd0, 32'd0, 0);          // bad opcode
    send(32'h02208133, 1, 4'b0000, 32'd0, 32'd0,   5'd0, 32'd0, 0);          // funct7=0000001
    check("illegal_cnt_2", illegal_cnt, 32'd2);
    check("retired_cnt_4", retired_cnt, 32'd4);
    send(32'h00500013, 0, 4'b0000, 32'd0, 32'd5,   5'd0, 32'd5, 0);          // addi x0,x0,5
    check("retired_rd0", retired_cnt, 32'd5);
    send(32'h40109093, 1, 4'b0000, 32'd0, 32'd0,   5'd0, 32'd0, 0);          // slli, imm[11:5]!=0
    send(32'h4020C1B3, 1, 4'b0000, 32'd0, 32'd0,   5'd0, 32'd0, 0);          // alt funct7 with xor
    send(32'h40004213, 0, 4'b0100, 32'd0, 32'h400, 5'd4, 32'h400, 0);        // xori x4,x0,0x400
    send(32'hFFF0F113, 0, 4'b0111, 32'd0, 32'hFFFFFFFF, 5'd2, 32'd0, 0);     // andi x2,x1,-1
    check("illegal_cnt_4", illegal_cnt, 32'd4);
    check("retired_cnt_7", retired_cnt, 32'd7);

    // Asynchronous reset while an addi x5 sits in EXEC.
    wait_ready();
    cpu_instruction         = 32'h00700293;
    cpu_instruction_RDY_BSY = 1'b1;
    @(negedge cpu_clk);
    cpu_instruction_RDY_BSY = 1'b0;
    @(negedge cpu_clk);
    check("pre_rst_exec_alu_b", alu_b, 32'd7);
    #2 cpu_rst = 1'b1;
    #1;
    check("async_rst_ready", 32'(cpu_instr_ready), 32'd1);
    check("async_rst_alu_b", alu_b, 32'd0);
    check("async_rst_raddr1", 32'(rf_raddr1), 32'd0);
    check("async_rst_retired", retired_cnt, 32'd0);
    check("async_rst_illegal", illegal_cnt, 32'd0);
    @(negedge cpu_clk);
    #2 cpu_rst = 1'b0;
    repeat (3) @(negedge cpu_clk);
    check("post_rst_ready", 32'(cpu_instr_ready), 32'd1);
    check("post_rst_retired", retired_cnt, 32'd0);

    // Source keeps valid high with changing data; only the transferred word executes.
    send(32'h00700293, 0, 4'b0000, 32'd0, 32'd7, 5'd5, 32'd7, 1);           // addi x5,x0,7
    @(negedge cpu_clk);
    check("idle_after_hold", 32'(cpu_instr_ready), 32'd1);
    check("retired_after_hold", retired_cnt, 32'd1);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=%0d exp=%0d", checks, 0);
    $fatal(1, "bench timeout");
  end

endmodule
